// File: rtl/sr_universal.sv
// Multi-cycle universal shift register: load, shift, rotate and arithmetic shift,
// one bit per clock, with a valid/ready command handshake and done/carry/err status.
module sr_universal #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH + 1),
   parameter int OP_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             op_valid,
   output logic             op_ready,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             done,
   output logic             err
);

   localparam logic [OP_W-1:0] OP_LOAD = OP_W'(8'h07);
   localparam logic [OP_W-1:0] OP_SHL  = OP_W'(8'h09);
   localparam logic [OP_W-1:0] OP_SHR  = OP_W'(8'h0B);
   localparam logic [OP_W-1:0] OP_ROL  = OP_W'(8'h0D);
   localparam logic [OP_W-1:0] OP_ROR  = OP_W'(8'h0F);
   localparam logic [OP_W-1:0] OP_ASR  = OP_W'(8'h11);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t             state_reg, state_next;
   logic [AMT_W-1:0]   cnt_reg;
   logic [OP_W-1:0]    op_reg;
   logic [WIDTH-1:0]   q_reg;
   logic               carry_reg;
   logic               done_reg;
   logic               err_reg;

   logic               accept;
   logic               op_is_shift;
   logic               op_is_valid;
   logic [WIDTH-1:0]   up_q, dn_q;
   logic               fill_lo, fill_hi;
   logic               step_left;
   logic [WIDTH-1:0]   step_q;
   logic               step_c;

   assign accept      = op_valid && (state_reg == ST_IDLE);
   assign op_is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
                        (op == OP_ROR) || (op == OP_ASR);
   assign op_is_valid = op_is_shift || (op == OP_LOAD);

   // One-bit moves in both directions; only the vacated end bit depends on the opcode.
   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_move
         assign up_q[gi]   = q_reg[gi-1];
         assign dn_q[gi-1] = q_reg[gi];
      end
   endgenerate

   assign fill_lo         = (op_reg == OP_ROL) ? q_reg[WIDTH-1] : 1'b0;
   assign fill_hi         = (op_reg == OP_ROR) ? q_reg[0] :
                            (op_reg == OP_ASR) ? q_reg[WIDTH-1] : 1'b0;
   assign up_q[0]         = fill_lo;
   assign dn_q[WIDTH-1]   = fill_hi;
   assign step_left       = (op_reg == OP_SHL) || (op_reg == OP_ROL);
   assign step_q          = step_left ? up_q : dn_q;
   assign step_c          = step_left ? q_reg[WIDTH-1] : q_reg[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (op_is_shift && (amt != '0)) begin
                  state_next = ST_SHIFT;
               end else begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            if (cnt_reg == AMT_W'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Command latch, datapath steps and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         op_reg    <= '0;
         q_reg     <= '0;
         carry_reg <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         done_reg <= (state_next == ST_DONE);
         err_reg  <= accept && !op_is_valid;
         if (accept) begin
            op_reg  <= op;
            cnt_reg <= amt;
            if (op == OP_LOAD) begin
               q_reg     <= data_in;
               carry_reg <= 1'b0;
            end
         end else if (state_reg == ST_SHIFT) begin
            q_reg     <= step_q;
            carry_reg <= step_c;
            cnt_reg   <= cnt_reg - AMT_W'(1);
         end
      end
   end

   always_comb begin
      op_ready = (state_reg == ST_IDLE);
      q        = q_reg;
      carry    = carry_reg;
      done     = done_reg;
      err      = err_reg;
   end

endmodule

// File: tb/tb_sr_universal.sv
// Bench for sr_universal (WIDTH=8): directed scenarios plus random commands, checked
// cycle by cycle against an arithmetic reference model of n-step shifts and rotates.
module tb_sr_universal;

   localparam logic [7:0] LOAD = 8'h07;
   localparam logic [7:0] SHL  = 8'h09;
   localparam logic [7:0] SHR  = 8'h0B;
   localparam logic [7:0] ROL  = 8'h0D;
   localparam logic [7:0] ROR  = 8'h0F;
   localparam logic [7:0] ASR  = 8'h11;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] op;
   logic [3:0] amt;
   logic [7:0] data_in;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] q;
   logic       carry;
   logic       done;
   logic       err;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q;
   logic       exp_c;

   sr_universal #(.WIDTH(8), .AMT_W(4), .OP_W(8)) dut (
      .clk(clk), .rst(rst), .op(op), .amt(amt), .data_in(data_in),
      .op_valid(op_valid), .op_ready(op_ready), .q(q), .carry(carry),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
      end
   endtask

   function automatic bit is_shift(input logic [7:0] o);
      return (o == SHL) || (o == SHR) || (o == ROL) || (o == ROR) || (o == ASR);
   endfunction

   // {carry, q} after n single-bit steps, computed in closed form.
   function automatic logic [8:0] model(input logic [7:0] o, input logic [7:0] q0,
                                        input logic c0, input logic [7:0] d, input int n);
      int x, s, m, r, c;
      x = int'(q0);
      s = q0[7] ? x - 256 : x;
      if (o == LOAD) return {1'b0, d};
      if (!is_shift(o) || n == 0) return {c0, q0};
      r = x;
      c = int'(c0);
      case (o)
         SHL: begin r = (n >= 8) ? 0 : (x << n) & 255; c = (n <= 8) ? (x >> (8 - n)) & 1 : 0; end
         SHR: begin r = (n >= 8) ? 0 : x >> n;         c = (n <= 8) ? (x >> (n - 1)) & 1 : 0; end
         ASR: begin r = (s >>> ((n > 8) ? 8 : n)) & 255; c = (s >>> ((n - 1 > 8) ? 8 : n - 1)) & 1; end
         ROL: begin m = n % 8; r = ((x << m) | (x >> (8 - m))) & 255; c = r & 1; end
         ROR: begin m = n % 8; r = ((x >> m) | (x << (8 - m))) & 255; c = (r >> 7) & 1; end
         default: ;
      endcase
      return {c[0], r[7:0]};
   endfunction

   // Issue one command from IDLE and check every cycle until it has retired.
   // With scramble set, op_valid stays high and op/amt/data_in churn while busy.
   task automatic issue(input logic [7:0] o, input logic [3:0] a, input logic [7:0] d,
                        input bit scramble);
      logic [8:0] r;
      logic [7:0] q0;
      logic       c0;
      int         n;
      q0 = exp_q;
      c0 = exp_c;
      n  = (is_shift(o) && a != 0) ? int'(a) : 0;
      op = o; amt = a; data_in = d; op_valid = 1'b1;
      @(negedge clk);
      check("ready_before_accept", op_ready, 1);
      @(posedge clk); #1;
      if (!scramble) op_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (scramble) begin
            op = SHL; amt = 4'($urandom_range(1, 15)); data_in = 8'($urandom);
         end
         @(negedge clk);
         r = model(o, q0, c0, d, k);
         check("step_q", q, r[7:0]);
         check("step_carry", carry, r[8]);
         check("busy_ready", op_ready, 0);
         check("busy_done", done, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      r = model(o, q0, c0, d, n);
      check("done_pulse", done, 1);
      check("done_err", err, (o == LOAD || is_shift(o)) ? 0 : 1);
      check("final_q", q, r[7:0]);
      check("final_carry", carry, r[8]);
      check("done_ready", op_ready, 0);
      op_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_err", err, 0);
      check("idle_ready", op_ready, 1);
      check("idle_q", q, r[7:0]);
      exp_q = r[7:0];
      exp_c = r[8];
      $display("cmd op=%02h amt=%0d din=%02h scr=%0d -> q=%02h carry=%0b", o, a, d, scramble, q, carry);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ops [7];
      rst = 1'b1; op = '0; amt = '0; data_in = '0; op_valid = 1'b0;
      exp_q = '0; exp_c = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_q", q, 0);
      check("rst_carry", carry, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      #1 check("rst_ready", op_ready, 1);
      @(posedge clk); #1;

      issue(LOAD, 4'd0, 8'h01, 1'b0);
      issue(SHL,  4'd4, 8'h00, 1'b0);
      issue(LOAD, 4'd0, 8'h90, 1'b0);
      issue(ASR,  4'd2, 8'h00, 1'b0);
      issue(LOAD, 4'd0, 8'hA5, 1'b0);
      issue(ROL,  4'd8, 8'h00, 1'b0);
      issue(LOAD, 4'd0, 8'h01, 1'b0);
      issue(ROR,  4'd3, 8'h00, 1'b0);

      // Reset in the middle of a shift aborts it without a done pulse.
      issue(LOAD, 4'd0, 8'hFF, 1'b0);
      op = SHL; amt = 4'd6; op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("abort_pre_q", q, 8'hFC);
      #2 rst = 1'b1;
      #1;
      check("abort_q", q, 0);
      check("abort_carry", carry, 0);
      check("abort_done", done, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q = '0; exp_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         check("abort_ready", op_ready, 1);
      end
      $display("cmd abort SHL amt=6 by rst -> q=%02h", q);
      @(posedge clk); #1;

      issue(LOAD, 4'd0, 8'h3C, 1'b0);
      issue(SHR,  4'd0, 8'h00, 1'b0);
      issue(8'h55, 4'd3, 8'h12, 1'b0);
      issue(SHL,  4'd3, 8'h00, 1'b1);
      issue(SHR,  4'd1, 8'h00, 1'b0);
      issue(LOAD, 4'd0, 8'h81, 1'b0);
      issue(ASR,  4'd12, 8'h00, 1'b0);
      issue(LOAD, 4'd0, 8'hC3, 1'b0);
      issue(SHL,  4'd9, 8'h00, 1'b0);

      ops[0] = LOAD; ops[1] = SHL; ops[2] = SHR; ops[3] = ROL;
      ops[4] = ROR;  ops[5] = ASR; ops[6] = 8'h00;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] o;
         o = ops[$urandom_range(0, 6)];
         if (o == 8'h00) o = 8'($urandom | 32'h80);
         issue(o, 4'($urandom_range(0, 15)), 8'($urandom), bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
